tribonacci_monitor: RTL
=======================

Name: tribonacci_monitor

Overview:
- Downstream checker for the tribonacci sequence generator. It samples the generator's term output, checks the seed terms, then checks every later term against the modular sum of the previous three.
- Counts accepted terms and flags the first arithmetic wrap-around. On the first mismatch it latches a sticky error with full diagnostics.
- Sits beside the generator in the self-checking top level and drives the pass/fail status.

Parameters:
WIDTH, 32, term width in bits, matching the generator output
CW, 16, width of term counter and index fields
SEED0, 0, required term 0
SEED1, 1, required term 1
SEED2, 1, required term 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  in_data holds a new term this cycle (tie 1 for a free-running generator)
in_data  in  WIDTH  sequence term (generator output s)
clr  in  1  synchronous restart: return to SEED0 and clear all status
state  out  2  0=SEED0, 1=SEED1, 2=SEED2, 3=CHECK/ERROR (see err)
term_count  out  CW  number of terms accepted without error
err  out  1  sticky mismatch flag
err_index  out  CW  0-based index of the failing term
err_expected  out  WIDTH  expected value at the failure
err_actual  out  WIDTH  received value at the failure
wrapped  out  1  sticky: some term's true sum exceeded 2^WIDTH-1
wrap_index  out  CW  index of the first wrapped term

Behaviour:
- Reset (rst_n=0, async): state=SEED0. All outputs 0. History registers h0/h1/h2 = 0.
- States: SEED0 -> SEED1 -> SEED2 -> CHECK. Any mismatch -> ERROR. ERROR exits only via clr or reset.
- A term is consumed only on a rising clk with in_valid=1. in_valid=0 leaves state, counters and history unchanged.
- SEEDk: compare in_data with SEEDk.
  - Match: shift history (h0<=h1, h1<=h2, h2<=in_data), term_count++, advance state.
  - Mismatch: go to ERROR; err_expected=SEEDk.
- CHECK: expected = (h0+h1+h2) mod 2^WIDTH. The sum is computed at WIDTH+2 bits.
  - Match: shift history, term_count++.
  - If the carry bits [WIDTH+1:WIDTH] are nonzero and wrapped=0: set wrapped=1 and wrap_index=term_count (pre-increment value).
  - Mismatch: go to ERROR.
- Entering ERROR, in one cycle: err=1, err_index=term_count, err_expected=expected, err_actual=in_data. term_count is not incremented.
- ERROR: all inputs except clr are ignored; all outputs hold. state reads 3.
- Latency: status outputs are registered. A term sampled at edge N is reflected in the outputs after edge N.
- term_count saturates at 2^CW-1. Once saturated, err_index and wrap_index also saturate.
- clr=1 on an edge: same values as reset. clr has priority over a simultaneous in_valid, and that term is dropped.
- The monitor takes no part in the generator's reset, which is separate (active-high). A generator restart without clr shows up as a mismatch at the restarted term. This is intended.
- Async reset asserted mid-sequence clears immediately. Deassertion is assumed to be synchronised upstream.

Test Plan:
- Reset, then 40 terms with in_valid=1: 0,1,1,2,4,7,13,...,2082876103,3831006429, then term 39 = 2751352088 (7046319384 mod 2^32).
  -> err=0, term_count=40, wrapped=1, wrap_index=39.
- WIDTH=8 instance fed 0,1,1,2,4,7,13,24,44,81,149, then 18 (274 mod 256).
  -> wrapped=1, wrap_index=11, term_count=12, err=0.
- Feed 0,1,1,2,4,8.
  -> after the 6th edge: err=1, err_index=5, err_expected=7, err_actual=8, term_count=5.
  -> further valid terms leave all outputs unchanged.
- Feed 1 as the first term.
  -> err=1, err_index=0, err_expected=0, err_actual=1.
- Toggle in_valid 1/0 every cycle over the legal sequence.
  -> same final results as the contiguous feed, and term_count increments only on valid cycles.
- In the error state, assert clr together with in_valid=1 (data 0).
  -> all status cleared, state=SEED0, term_count=0.
  -> the term sampled with clr is dropped; the next 0,1,1,2 is accepted with term_count=4.
  -> rst_n pulsed low mid-CHECK clears outputs asynchronously, before the next clock edge.

Source files
------------

// File: rtl/tribonacci_monitor_if.sv
// Term stream and status bundle between a tribonacci generator/testbench and the monitor.
interface tribonacci_monitor_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CW    = 16
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             clr;
   logic [1:0]       state;
   logic [CW-1:0]    term_count;
   logic             err;
   logic [CW-1:0]    err_index;
   logic [WIDTH-1:0] err_expected;
   logic [WIDTH-1:0] err_actual;
   logic             wrapped;
   logic [CW-1:0]    wrap_index;

   modport master (
      output in_valid, in_data, clr,
      input  state, term_count, err, err_index, err_expected, err_actual, wrapped, wrap_index
   );

   modport slave (
      input  in_valid, in_data, clr,
      output state, term_count, err, err_index, err_expected, err_actual, wrapped, wrap_index
   );
endinterface

// File: rtl/tribonacci_monitor.sv
// Checks a tribonacci term stream: seeds first, then each term against the modular sum of the
// previous three. Latches a sticky error with diagnostics and records the first wrap-around.
module tribonacci_monitor #(
   parameter int unsigned      WIDTH = 32,
   parameter int unsigned      CW    = 16,
   parameter logic [WIDTH-1:0] SEED0 = WIDTH'(0),
   parameter logic [WIDTH-1:0] SEED1 = WIDTH'(1),
   parameter logic [WIDTH-1:0] SEED2 = WIDTH'(1)
) (
   input logic                  clk,
   input logic                  rst_n,
   tribonacci_monitor_if.slave  mon_if
);

   typedef enum logic [2:0] {StSeed0, StSeed1, StSeed2, StCheck, StError} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;
   logic [CW-1:0]    count_q, count_d;
   logic             err_q, err_d;
   logic [CW-1:0]    err_index_q, err_index_d;
   logic [WIDTH-1:0] err_exp_q, err_exp_d;
   logic [WIDTH-1:0] err_act_q, err_act_d;
   logic             wrapped_q, wrapped_d;
   logic [CW-1:0]    wrap_index_q, wrap_index_d;

   logic [WIDTH+1:0] sum_full;
   logic [WIDTH-1:0] expected;
   logic             match;
   logic [CW-1:0]    count_inc;

   // Two guard bits keep the true three-term sum so wrap-around is visible.
   assign sum_full  = {2'b00, h0_q} + {2'b00, h1_q} + {2'b00, h2_q};
   assign match     = (mon_if.in_data == expected);
   assign count_inc = (count_q == {CW{1'b1}}) ? count_q : count_q + CW'(1);

   always_comb begin
      expected = sum_full[WIDTH-1:0];
      case (state_q)
         StSeed0: expected = SEED0;
         StSeed1: expected = SEED1;
         StSeed2: expected = SEED2;
         default: expected = sum_full[WIDTH-1:0];
      endcase
   end

   always_comb begin
      state_d      = state_q;
      h0_d         = h0_q;
      h1_d         = h1_q;
      h2_d         = h2_q;
      count_d      = count_q;
      err_d        = err_q;
      err_index_d  = err_index_q;
      err_exp_d    = err_exp_q;
      err_act_d    = err_act_q;
      wrapped_d    = wrapped_q;
      wrap_index_d = wrap_index_q;

      if (mon_if.clr) begin
         state_d      = StSeed0;
         h0_d         = '0;
         h1_d         = '0;
         h2_d         = '0;
         count_d      = '0;
         err_d        = 1'b0;
         err_index_d  = '0;
         err_exp_d    = '0;
         err_act_d    = '0;
         wrapped_d    = 1'b0;
         wrap_index_d = '0;
      end else if (mon_if.in_valid && (state_q != StError)) begin
         if (match) begin
            h0_d    = h1_q;
            h1_d    = h2_q;
            h2_d    = mon_if.in_data;
            count_d = count_inc;
            case (state_q)
               StSeed0: state_d = StSeed1;
               StSeed1: state_d = StSeed2;
               default: state_d = StCheck;
            endcase
            if ((state_q == StCheck) && (sum_full[WIDTH+1:WIDTH] != 2'b00) && !wrapped_q) begin
               wrapped_d    = 1'b1;
               wrap_index_d = count_q;
            end
         end else begin
            state_d     = StError;
            err_d       = 1'b1;
            err_index_d = count_q;
            err_exp_d   = expected;
            err_act_d   = mon_if.in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StSeed0;
         h0_q         <= '0;
         h1_q         <= '0;
         h2_q         <= '0;
         count_q      <= '0;
         err_q        <= 1'b0;
         err_index_q  <= '0;
         err_exp_q    <= '0;
         err_act_q    <= '0;
         wrapped_q    <= 1'b0;
         wrap_index_q <= '0;
      end else begin
         state_q      <= state_d;
         h0_q         <= h0_d;
         h1_q         <= h1_d;
         h2_q         <= h2_d;
         count_q      <= count_d;
         err_q        <= err_d;
         err_index_q  <= err_index_d;
         err_exp_q    <= err_exp_d;
         err_act_q    <= err_act_d;
         wrapped_q    <= wrapped_d;
         wrap_index_q <= wrap_index_d;
      end
   end

   always_comb begin
      mon_if.state = 2'd3;
      case (state_q)
         StSeed0: mon_if.state = 2'd0;
         StSeed1: mon_if.state = 2'd1;
         StSeed2: mon_if.state = 2'd2;
         default: mon_if.state = 2'd3;
      endcase
   end

   assign mon_if.term_count   = count_q;
   assign mon_if.err          = err_q;
   assign mon_if.err_index    = err_index_q;
   assign mon_if.err_expected = err_exp_q;
   assign mon_if.err_actual   = err_act_q;
   assign mon_if.wrapped      = wrapped_q;
   assign mon_if.wrap_index   = wrap_index_q;

endmodule
